// File: rtl/ecc_enc_dec_q.sv
// ecc_enc_dec_q: queued extended-Hamming (SECDED) encode/decode engine behind an APB slave.
// Ports:
//   clk, rst            - single clock, asynchronous active-high reset
//   PADDR/PWDATA/PENABLE/PSEL/PWRITE/PRDATA - APB slave (no wait states)
//   data_out            - last result word, zero-extended
//   operation_done      - one-cycle pulse when data_out/num_of_errors update
//   num_of_errors       - 0 none, 1 corrected, 2 double detected
//   fifo_full           - command queue full
`timescale 1ns/1ps
module ecc_enc_dec_q #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned AMBA_ADDR_WIDTH = 20,
  parameter int unsigned AMBA_WORD       = 32,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  input  logic                       PENABLE,
  input  logic                       PSEL,
  input  logic                       PWRITE,
  output logic [AMBA_WORD-1:0]       PRDATA,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       operation_done,
  output logic [1:0]                 num_of_errors,
  output logic                       fifo_full
);

  localparam int unsigned DW   = DATA_WIDTH;
  localparam int unsigned SW   = $clog2(DATA_WIDTH);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned CW   = 16;

  typedef struct packed {
    logic [1:0]    op;
    logic [1:0]    wcode;
    logic [DW-1:0] data;
    logic [DW-1:0] noise;
  } cmd_t;

  typedef struct packed {
    logic [1:0]    err;
    logic [DW-1:0] data;
  } res_t;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_POP = 2'd1, S_EXEC = 2'd2} state_t;

  function automatic logic f_is_pow2(input int unsigned k);
    return ((k & (k - 1)) == 32'd0);
  endfunction

  // Data bit index stored at non-power-of-two position k (k >= 3).
  function automatic int unsigned f_didx(input int unsigned k);
    int unsigned np;
    np = 0;
    for (int unsigned i = 0; i < 6; i++)
      if ((32'd1 << i) <= k) np++;
    return k - np - 1;
  endfunction

  function automatic int unsigned f_width(input logic [1:0] code);
    int unsigned n;
    case (code)
      2'd0:    n = 8;
      2'd1:    n = 16;
      default: n = 32;
    endcase
    if (n > DW) n = DW;
    return n;
  endfunction

  function automatic logic [DW-1:0] f_encode(input logic [DW-1:0] d, input int unsigned n);
    logic [DW-1:0] cw;
    logic          par;
    cw = '0;
    for (int unsigned k = 3; k < DW; k++)
      if (k < n && !f_is_pow2(k)) cw[SW'(k)] = d[SW'(f_didx(k))];
    // Positions >= n are still zero, so check bits beyond n come out zero.
    for (int unsigned i = 0; i < SW; i++) begin
      par = 1'b0;
      for (int unsigned k = 1; k < DW; k++)
        if ((k & (32'd1 << i)) != 32'd0) par ^= cw[SW'(k)];
      cw[SW'(32'd1 << i)] = par;
    end
    cw[0] = ^cw;
    return cw;
  endfunction

  function automatic res_t f_decode(input logic [DW-1:0] cw, input int unsigned n);
    logic [DW-1:0] c;
    logic [SW-1:0] s;
    logic          p;
    res_t          r;
    c = '0;
    for (int unsigned k = 0; k < DW; k++)
      if (k < n) c[SW'(k)] = cw[SW'(k)];
    s = '0;
    for (int unsigned k = 1; k < DW; k++)
      if (c[SW'(k)]) s ^= SW'(k);
    p = ^c;
    // Odd parity means one error; syndrome 0 points at the parity bit itself.
    if (p) c[s] = ~c[s];
    r.data = '0;
    for (int unsigned k = 3; k < DW; k++)
      if (k < n && !f_is_pow2(k)) r.data[SW'(f_didx(k))] = c[SW'(k)];
    r.err = p ? 2'd1 : ((s != '0) ? 2'd2 : 2'd0);
    return r;
  endfunction

  function automatic res_t f_exec(input cmd_t c);
    res_t        r;
    int unsigned n;
    n = f_width(c.wcode);
    case (c.op)
      2'd1:    r = f_decode(c.data, n);
      2'd2:    r = f_decode(f_encode(c.data, n) ^ c.noise, n);
      default: begin
        r.data = f_encode(c.data, n);
        r.err  = 2'd0;
      end
    endcase
    return r;
  endfunction

  state_t                r_state, w_state_nxt;
  logic                  w_pop, w_busy;
  cmd_t                  r_fifo [FIFO_DEPTH];
  logic [AW-1:0]         r_wptr, r_rptr;
  logic [CNTW-1:0]       r_count, w_count_nxt;
  logic [1:0]            r_ctrl;
  logic [AMBA_WORD-1:0]  r_data_in, r_noise;
  logic [2:0]            r_cfg;
  logic                  r_ovf;
  logic [CW-1:0]         r_cnt_ops, r_cnt_corr, r_cnt_double;
  logic [DW-1:0]         r_data_out;
  logic                  r_done, r_full;
  logic [1:0]            r_noe;
  logic                  w_wr, w_push, w_full_now, w_push_ok, w_ovf_set;
  logic [2:0]            w_wsel;
  cmd_t                  w_cmd;
  res_t                  w_res;
  logic                  w_unused;

  assign w_wr        = PSEL & PENABLE & PWRITE;
  assign w_wsel      = PADDR[4:2];
  assign w_push      = w_wr && (w_wsel == 3'd0) && (PWDATA[1:0] != 2'd3);
  assign w_full_now  = (r_count == CNTW'(FIFO_DEPTH));
  assign w_push_ok   = w_push && (!w_full_now || w_pop);
  assign w_ovf_set   = w_push && w_full_now && !w_pop;
  assign w_count_nxt = r_count + CNTW'(w_push_ok) - CNTW'(w_pop);
  assign w_cmd       = '{op: PWDATA[1:0], wcode: r_cfg[1:0],
                         data: r_data_in[DW-1:0], noise: r_noise[DW-1:0]};
  assign w_res       = f_exec(r_fifo[r_rptr]);
  assign w_unused    = ^{PADDR[AMBA_ADDR_WIDTH-1:5], PADDR[1:0]};

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Sequencer next state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_count != '0 && !r_cfg[2]) w_state_nxt = S_POP;
      S_POP:   w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sequencer decoded controls.
  always_comb begin
    w_pop  = 1'b0;
    w_busy = 1'b0;
    case (r_state)
      S_POP:   begin w_pop = 1'b1; w_busy = 1'b1; end
      S_EXEC:  w_busy = 1'b1;
      default: ;
    endcase
  end

  // Command queue storage; contents are don't-care outside the valid window.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_fifo[r_wptr] <= w_cmd;
  end

  // Queue pointers, level and full flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop)     r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNTW'(FIFO_DEPTH));
    end
  end

  // Software-visible registers and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl    <= '0;
      r_data_in <= '0;
      r_cfg     <= '0;
      r_noise   <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_wr) begin
        case (w_wsel)
          3'd0:    r_ctrl    <= PWDATA[1:0];
          3'd1:    r_data_in <= PWDATA;
          3'd2:    r_cfg     <= PWDATA[2:0];
          3'd3:    r_noise   <= PWDATA;
          default: ;
        endcase
      end
      if (w_wr && w_wsel == 3'd4) r_ovf <= 1'b0;
      else if (w_ovf_set)         r_ovf <= 1'b1;
    end
  end

  // Result is computed from the queue head while popping and registered at that edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_out <= '0;
      r_noe      <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_pop;
      if (w_pop) begin
        r_data_out <= w_res.data;
        r_noe      <= w_res.err;
      end
    end
  end

  // Saturating statistics; a write to a counter takes priority over an increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_ops    <= '0;
      r_cnt_corr   <= '0;
      r_cnt_double <= '0;
    end else begin
      if (w_wr && w_wsel == 3'd5) r_cnt_ops <= '0;
      else if (w_pop && r_cnt_ops != '1) r_cnt_ops <= r_cnt_ops + CW'(1);
      if (w_wr && w_wsel == 3'd6) r_cnt_corr <= '0;
      else if (w_pop && w_res.err == 2'd1 && r_cnt_corr != '1) r_cnt_corr <= r_cnt_corr + CW'(1);
      if (w_wr && w_wsel == 3'd7) r_cnt_double <= '0;
      else if (w_pop && w_res.err == 2'd2 && r_cnt_double != '1) r_cnt_double <= r_cnt_double + CW'(1);
    end
  end

  // APB read mux.
  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      case (PADDR[4:2])
        3'd0:    PRDATA = AMBA_WORD'(r_ctrl);
        3'd1:    PRDATA = r_data_in;
        3'd2:    PRDATA = AMBA_WORD'(r_cfg);
        3'd3:    PRDATA = r_noise;
        3'd4:    PRDATA = AMBA_WORD'({r_ovf, w_busy, 8'(r_count)});
        3'd5:    PRDATA = AMBA_WORD'(r_cnt_ops);
        3'd6:    PRDATA = AMBA_WORD'(r_cnt_corr);
        default: PRDATA = AMBA_WORD'(r_cnt_double);
      endcase
    end
  end

  assign data_out       = r_data_out;
  assign operation_done = r_done;
  assign num_of_errors  = r_noe;
  assign fifo_full      = r_full;

endmodule
